// File: rtl/bus_pkg.sv
// Shared op codes, T-state encodings and op decoding for the Z80-style bus initiator.
package bus_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_FETCH = 3'd0;
   localparam op_t OP_MEMRD = 3'd1;
   localparam op_t OP_MEMWR = 3'd2;
   localparam op_t OP_IORD  = 3'd3;
   localparam op_t OP_IOWR  = 3'd4;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_T1   = 3'd1;
   localparam logic [2:0] ST_T2   = 3'd2;
   localparam logic [2:0] ST_TW   = 3'd3;
   localparam logic [2:0] ST_T3   = 3'd4;
   localparam logic [2:0] ST_T4   = 3'd5;

   localparam int         WCNT_W        = 4;
   localparam logic [3:0] IO_AUTO_WAITS = 4'd1;

   typedef struct packed {
      logic fetch;
      logic io;
      logic write;
   } op_attr_t;

   function automatic logic op_valid(input op_t op);
      return op <= OP_IOWR;
   endfunction

   function automatic op_attr_t decode_op(input op_t op);
      op_attr_t attr;
      attr.fetch = (op == OP_FETCH);
      attr.io    = (op == OP_IORD) || (op == OP_IOWR);
      attr.write = (op == OP_MEMWR) || (op == OP_IOWR);
      return attr;
   endfunction

endpackage

// File: rtl/bus_initiator.sv
// Z80-style bus cycle sequencer: fetch, memory and io cycles with wait-state insertion,
// advancing one T-state per ce.
module bus_initiator
   import bus_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic        req,
   input  logic [2:0]  op,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic        busy,
   output logic        done,
   output logic [7:0]  rdata,
   output logic        mreq,
   output logic        iorq,
   output logic        m1,
   output logic        rd,
   output logic        wr,
   output logic [15:0] a,
   output logic [7:0]  dout,
   output logic        doe,
   input  logic [7:0]  din,
   input  logic        waitn
);

   logic [2:0]        state_q, state_d;
   op_attr_t          attr_q, attr_d;
   logic [15:0]       addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              done_q, done_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

   op_attr_t          req_attr;
   logic [WCNT_W-1:0] min_waits;
   logic              in_t1_t3;
   logic              in_t2_t3;

   assign req_attr  = decode_op(op);
   assign min_waits = attr_q.io ? IO_AUTO_WAITS : '0;

   always_comb begin
      state_d    = state_q;
      attr_d     = attr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      wait_cnt_d = wait_cnt_q;
      done_d     = 1'b0;
      if (ce) begin
         case (state_q)
            ST_IDLE: begin
               if (req && op_valid(op)) begin
                  attr_d     = req_attr;
                  addr_d     = addr;
                  wdata_d    = wdata;
                  wait_cnt_d = '0;
                  state_d    = ST_T1;
               end
            end
            ST_T1: state_d = ST_T2;
            // io cycles owe their automatic wait first; after that waitn decides
            ST_T2, ST_TW: begin
               if ((wait_cnt_q < min_waits) || !waitn) begin
                  state_d = ST_TW;
                  if (wait_cnt_q != '1) begin
                     wait_cnt_d = wait_cnt_q + 1'b1;
                  end
               end else begin
                  state_d = ST_T3;
               end
            end
            ST_T3: begin
               if (!attr_q.write) begin
                  rdata_d = din;
               end
               if (attr_q.fetch) begin
                  state_d = ST_T4;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
            ST_T4: begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         attr_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         attr_q     <= attr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         done_q     <= done_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Strobes decode straight from registered state, so they only move on ce edges
   assign in_t1_t3 = (state_q == ST_T1) || (state_q == ST_T2) ||
                     (state_q == ST_TW) || (state_q == ST_T3);
   assign in_t2_t3 = (state_q == ST_T2) || (state_q == ST_TW) || (state_q == ST_T3);

   assign busy  = (state_q != ST_IDLE);
   assign done  = done_q;
   assign rdata = rdata_q;
   assign a     = busy ? addr_q : 16'h0000;
   assign m1    = !(attr_q.fetch && in_t1_t3);
   assign mreq  = !(!attr_q.io && in_t2_t3);
   assign iorq  = !(attr_q.io && in_t2_t3);
   assign rd    = !(!attr_q.write && in_t2_t3);
   assign wr    = !(attr_q.write && in_t2_t3);
   assign doe   = attr_q.write && in_t1_t3;
   assign dout  = doe ? wdata_q : 8'h00;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: cycle shapes, wait states, ce gating and reset.
module tb_bus_initiator;
   import bus_pkg::*;

   logic        clock;
   logic        reset;
   logic        ce;
   logic        req;
   logic [2:0]  op;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        busy;
   logic        done;
   logic [7:0]  rdata;
   logic        mreq;
   logic        iorq;
   logic        m1;
   logic        rd;
   logic        wr;
   logic [15:0] a;
   logic [7:0]  dout;
   logic        doe;
   logic [7:0]  din;
   logic        waitn;
   logic [4:0]  strb;

   int tests;
   int fails;
   int n_m1, n_mreq, n_iorq, n_rd, n_wr, n_doe, len;
   logic got_done;
   logic [4:0] last_strb;
   logic [7:0] data_e3;
   logic automap;
   int n_busy, n_done, n_bad;

   bus_initiator dut (
      .clock (clock),
      .reset (reset),
      .ce    (ce),
      .req   (req),
      .op    (op),
      .addr  (addr),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .rdata (rdata),
      .mreq  (mreq),
      .iorq  (iorq),
      .m1    (m1),
      .rd    (rd),
      .wr    (wr),
      .a     (a),
      .dout  (dout),
      .doe   (doe),
      .din   (din),
      .waitn (waitn)
   );

   // strobe vector order: m1, mreq, iorq, rd, wr (all active low)
   assign strb = {m1, mreq, iorq, rd, wr};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Accept one cycle, then walk it to done, pulling waitn low for samples [ws, ws+wn).
   task automatic run_cycle(input logic [2:0] o, input logic [15:0] ad, input logic [7:0] wd,
                            input int ws, input int wn);
      op = o; addr = ad; wdata = wd; req = 1'b1; ce = 1'b1;
      tick();
      req = 1'b0;
      n_m1 = 0; n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0; n_doe = 0; len = 0;
      got_done = 1'b0; last_strb = 5'h00;
      for (int i = 0; i < 20 && !got_done; i++) begin
         if (!m1)   n_m1++;
         if (!mreq) n_mreq++;
         if (!iorq) n_iorq++;
         if (!rd)   n_rd++;
         if (!wr)   n_wr++;
         if (doe)   n_doe++;
         if (!iorq && !wr && a[7:0] == 8'hE3) data_e3 = dout;
         if (!m1 && !mreq && !rd && a == 16'h0038) automap = 1'b1;
         last_strb = strb;
         waitn = (i >= ws && i < ws + wn) ? 1'b0 : 1'b1;
         tick();
         len++;
         if (done) got_done = 1'b1;
      end
      waitn = 1'b1;
      chk("cycle_done_seen", {31'd0, got_done}, 32'd1);
   endtask

   initial begin
      tests = 0; fails = 0;
      data_e3 = 8'h00; automap = 1'b0;
      reset = 1'b0; ce = 1'b0; req = 1'b0; op = 3'd0; addr = 16'h0; wdata = 8'h0;
      din = 8'h00; waitn = 1'b1;
      tick(); tick();
      chk("rst_strobes", {27'd0, strb}, 32'h1F);
      chk("rst_a", {16'd0, a}, 32'h0);
      chk("rst_dout", {24'd0, dout}, 32'h0);
      chk("rst_doe", {31'd0, doe}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      chk("rst_done", {31'd0, done}, 32'h0);
      chk("rst_rdata", {24'd0, rdata}, 32'h0);

      // release with ce low and a request pending: nothing may start
      reset = 1'b1; req = 1'b1; op = OP_MEMRD; addr = 16'h1111;
      tick(); tick(); tick();
      chk("no_accept_without_ce", {31'd0, busy}, 32'h0);
      chk("no_accept_strobes", {27'd0, strb}, 32'h1F);
      req = 1'b0; ce = 1'b1;
      tick();

      // io write to 0xE3
      run_cycle(OP_IOWR, 16'h00E3, 8'h83, 0, 0);
      chk("iowr_len", len, 32'd4);
      chk("iowr_iorq", n_iorq, 32'd3);
      chk("iowr_wr", n_wr, 32'd3);
      chk("iowr_doe", n_doe, 32'd4);
      chk("iowr_mreq", n_mreq, 32'd0);
      chk("iowr_mapper_e3", {24'd0, data_e3}, 32'h83);
      chk("iowr_busy_clear", {31'd0, busy}, 32'h0);
      chk("iowr_idle_a", {16'd0, a}, 32'h0);

      // opcode fetch of RST 38h
      din = 8'hF3;
      run_cycle(OP_FETCH, 16'h0038, 8'h00, 0, 0);
      chk("fetch_len", len, 32'd4);
      chk("fetch_m1", n_m1, 32'd3);
      chk("fetch_mreq", n_mreq, 32'd2);
      chk("fetch_rd", n_rd, 32'd2);
      chk("fetch_t4_strobes", {27'd0, last_strb}, 32'h1F);
      chk("fetch_rdata", {24'd0, rdata}, 32'hF3);
      chk("fetch_automap", {31'd0, automap}, 32'h1);

      // memory read with two waits requested at T2
      din = 8'h5A;
      run_cycle(OP_MEMRD, 16'h3D00, 8'h00, 1, 2);
      chk("memrd_wait_len", len, 32'd5);
      chk("memrd_wait_mreq", n_mreq, 32'd4);
      chk("memrd_wait_rd", n_rd, 32'd4);
      chk("memrd_wait_m1", n_m1, 32'd0);
      chk("memrd_rdata", {24'd0, rdata}, 32'h5A);

      // memory write; waitn low during T1 is not sampled
      din = 8'hEE;
      run_cycle(OP_MEMWR, 16'h1234, 8'hA5, 0, 1);
      chk("memwr_len", len, 32'd3);
      chk("memwr_mreq", n_mreq, 32'd2);
      chk("memwr_wr", n_wr, 32'd2);
      chk("memwr_doe", n_doe, 32'd3);
      chk("memwr_rdata_held", {24'd0, rdata}, 32'h5A);

      // io read: waitn low in the automatic TW adds one more
      din = 8'h77;
      run_cycle(OP_IORD, 16'h00FE, 8'h00, 2, 1);
      chk("iord_wait_len", len, 32'd5);
      chk("iord_wait_iorq", n_iorq, 32'd4);
      chk("iord_wait_rd", n_rd, 32'd4);
      chk("iord_rdata", {24'd0, rdata}, 32'h77);

      // io read: waitn low at T2 only is ignored
      din = 8'h66;
      run_cycle(OP_IORD, 16'h00FD, 8'h00, 1, 1);
      chk("iord_t2_wait_ignored", len, 32'd4);
      chk("iord_rdata2", {24'd0, rdata}, 32'h66);

      // ce gating in the middle of a memory write
      op = OP_MEMWR; addr = 16'h0100; wdata = 8'h11; req = 1'b1; ce = 1'b1;
      tick();
      req = 1'b0; ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ce0_t1_strobes", {27'd0, strb}, 32'h1F);
         chk("ce0_t1_doe", {31'd0, doe}, 32'h1);
         chk("ce0_t1_busy", {31'd0, busy}, 32'h1);
      end
      chk("ce0_t1_dout", {24'd0, dout}, 32'h11);
      chk("ce0_t1_a", {16'd0, a}, 32'h0100);
      ce = 1'b1;
      tick();
      chk("ce1_t2_strobes", {27'd0, strb}, 32'h16);
      ce = 1'b0;
      tick(); tick();
      chk("ce0_t2_strobes", {27'd0, strb}, 32'h16);
      chk("ce0_t2_done", {31'd0, done}, 32'h0);
      ce = 1'b1;
      tick();
      chk("ce1_t3_strobes", {27'd0, strb}, 32'h16);
      tick();
      chk("ce_gated_done", {31'd0, done}, 32'h1);
      ce = 1'b0;
      tick();
      chk("done_one_clock", {31'd0, done}, 32'h0);
      ce = 1'b1;

      // reset while an io read sits in TW
      op = OP_IORD; addr = 16'h00FE; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      waitn = 1'b0;
      tick();
      chk("iord_tw_strobes", {27'd0, strb}, 32'h19);
      reset = 1'b0;
      #1;
      chk("midrst_strobes", {27'd0, strb}, 32'h1F);
      chk("midrst_busy", {31'd0, busy}, 32'h0);
      chk("midrst_a", {16'd0, a}, 32'h0);
      chk("midrst_rdata", {24'd0, rdata}, 32'h0);
      tick(); tick();
      waitn = 1'b1;
      reset = 1'b1;
      n_done = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) n_done++;
      end
      chk("midrst_no_done", n_done, 32'd0);
      din = 8'h42;
      run_cycle(OP_MEMRD, 16'h2000, 8'h00, 0, 0);
      chk("post_rst_len", len, 32'd3);
      chk("post_rst_rdata", {24'd0, rdata}, 32'h42);

      // req held high: one write per acceptance, an IDLE ce between each
      tick();
      op = OP_MEMWR; addr = 16'h4000; wdata = 8'h3C; req = 1'b1;
      n_busy = 0; n_done = 0; n_bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy) n_busy++;
         if (done) n_done++;
         if (done && busy) n_bad++;
      end
      req = 1'b0;
      chk("held_req_done_count", n_done, 32'd3);
      chk("held_req_busy_count", n_busy, 32'd9);
      chk("held_req_idle_gap", n_bad, 32'd0);
      tick();

      // invalid op: no bus activity at all
      op = 3'd6; req = 1'b1; n_bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (busy || done || strb != 5'h1F || doe || a != 16'h0) n_bad++;
      end
      req = 1'b0;
      chk("invalid_op_quiet", n_bad, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Clock/reset SHALL be: reset reset, asynchronous, active-low; clock clock.
REQ-002 clock  input  1  system clock.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 ce  input  1  T-state enable; every FSM advance and every bus-signal change SHALL occur on a clock edge with ce=1.
REQ-005 req  input  1  cycle request, sampled only in IDLE with ce=1.
REQ-006 op  input  3  cycle type: 0 opcode fetch, 1 mem read, 2 mem write, 3 io read, 4 io write; 5-7 invalid.
REQ-007 addr  input  16  cycle address; wdata  input  8  write data.
REQ-008 busy  output  1  high from acceptance until return to IDLE.
REQ-009 done  output  1  one-clock pulse at cycle completion.
REQ-010 rdata  output  8  captured read/fetch data, held until the next read completes.
REQ-011 mreq, iorq, m1, rd, wr  output  1 each  Z80-style active-low strobes.
REQ-012 a  output  16  bus address; dout  output  8  write data; doe  output  1  data-bus drive enable.
REQ-013 din  input  8  bus read data; waitn  input  1  active-low wait.

Function
REQ-014 FSM states SHALL be IDLE, T1, T2, TW, T3, T4.
REQ-015 In IDLE with ce=1 and req=1 and op<=4, op/addr/wdata SHALL be latched, busy set and the state SHALL become T1; op>=5 SHALL be ignored, with no busy and no done.
REQ-016 req SHALL be ignored while busy=1.
REQ-017 a SHALL equal the latched addr in T1..T4 and 0x0000 in IDLE.
REQ-018 m1 SHALL be low in T1, T2, TW and T3 of a fetch only.
REQ-019 mreq (memory/fetch) or iorq (io) SHALL be low in T2, TW and T3.
REQ-020 rd (reads/fetch) or wr (writes) SHALL be low in T2, TW and T3.
REQ-021 doe SHALL be high and dout SHALL equal wdata from T1 through T3 of write cycles; otherwise doe=0 and dout=0.
REQ-022 io cycles SHALL always insert exactly one automatic TW after T2.
REQ-023 waitn SHALL be sampled at the ce ending T2 (memory/fetch) or ending each TW (io, including the automatic TW); while low, further TW states SHALL be inserted, one per ce.
REQ-024 Base lengths SHALL be: memory 3 T, io 4 T, fetch 4 T (T4 with all strobes high and m1 high), plus inserted waits.
REQ-025 rdata SHALL capture din at the ce ending T3 for read and fetch cycles.
REQ-026 At the ce ending the last T-state, the state SHALL become IDLE, busy SHALL clear and done SHALL pulse for exactly one clock.
REQ-027 A req present at the same ce that returns to IDLE SHALL NOT be accepted; acceptance SHALL occur at the next ce at the earliest.
REQ-028 With ce=0, all outputs SHALL hold their values and done SHALL be 0.

Reset
REQ-029 Reset SHALL force IDLE, all strobes high, a=0, dout=0, doe=0, busy=0, done=0 and rdata=0, including when asserted mid-cycle.
REQ-030 After reset release, the first cycle SHALL be accepted no earlier than the first ce.

Structure
REQ-031 Op codes (3-bit) and the state enumeration SHALL be placed in a shared package, bus_pkg, used by the bus mapper bench.
REQ-032 The block SHALL be a single module with no sub-module; the T-state sequencing SHALL be one FSM plus a wait-state counter for coverage.

Verification
REQ-033 io write, addr=0x00E3, wdata=0x83, waitn=1 -> iorq/wr low for 3 ce (T2, TW, T3), doe high for 4 ce, done 4 ce after acceptance, and a mapper bench sees dataE3=0x83.
REQ-034 Fetch, addr=0x0038, din=0xF3 -> m1 low for 3 ce, mreq/rd low for 2 ce, T4 with all strobes high, rdata=0xF3, done after 4 ce, and the mapper automap set on the next cycle.
REQ-035 Mem read, addr=0x3D00, waitn low for 2 ce at T2 -> 2 TW inserted, mreq low for 4 ce, done after 5 ce.
REQ-036 Reset asserted during TW of an io read -> all strobes high immediately, busy=0, no done pulse, and the next req accepted normally.
REQ-037 req held high across done with op=2 -> exactly one cycle per acceptance, with at least one IDLE ce between cycles; op=6 -> no bus activity.
